// File: rtl/reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_bank_pkg : shared widths, register indices and reset defaults    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package reg_bank_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int SP_RESET_DEF = 227;
  localparam int NUM_REGS     = 32;
  localparam int IDX_W        = 5;

  typedef logic [IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage : reg_bank_pkg
`default_nettype wire

// File: rtl/reg_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_bank_if : write port, two read ports and operand-latch controls  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface reg_bank_if
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              reg_write;
  reg_idx_t          write_reg;
  logic [DATA_W-1:0] write_data;
  reg_idx_t          read_reg1;
  reg_idx_t          read_reg2;
  logic              load_a;
  logic              load_b;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;

  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2, load_a, load_b,
    input  read_data1, read_data2, reg_a, reg_b
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2, load_a, load_b,
    output read_data1, read_data2, reg_a, reg_b
  );
endinterface : reg_bank_if
`default_nettype wire

// File: rtl/reg_bank_oper_latch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_bank_oper_latch : load-enabled operand register, sync reset      |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module reg_bank_oper_latch
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_load,
  input  wire logic [DATA_W-1:0] i_d,
  output logic      [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : reg_bank_oper_latch
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_bank : 32-entry register file, two async reads, one sync write,  |
// |            plus registered operands A/B.                             |
// | Option   : REG_BANK_BYPASS_EN forwards write_data to matching reads  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SP_RESET = SP_RESET_DEF,
  parameter int RA_RESET = 0
) (
  input  wire logic   clk,
  input  wire logic   reset,
  reg_bank_if.slave   bus
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_reg_a;
  logic [DATA_W-1:0] w_reg_b;

  // Index 0 is never a write target, which also keeps it out of forwarding.
  assign w_wr_en = bus.reg_write && (bus.write_reg != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == int'(REG_SP)) begin
          r_regs[i] <= DATA_W'(SP_RESET);
        end else if (i == int'(REG_RA)) begin
          r_regs[i] <= DATA_W'(RA_RESET);
        end else begin
          r_regs[i] <= '0;
        end
      end
    end else if (w_wr_en) begin
      r_regs[bus.write_reg] <= bus.write_data;
    end
  end

  always_comb begin
    w_rd1 = (bus.read_reg1 == REG_ZERO) ? '0 : r_regs[bus.read_reg1];
    w_rd2 = (bus.read_reg2 == REG_ZERO) ? '0 : r_regs[bus.read_reg2];
`ifdef REG_BANK_BYPASS_EN
    if (w_wr_en && (bus.write_reg == bus.read_reg1)) begin
      w_rd1 = bus.write_data;
    end
    if (w_wr_en && (bus.write_reg == bus.read_reg2)) begin
      w_rd2 = bus.write_data;
    end
`else
`endif
  end

  assign bus.read_data1 = w_rd1;
  assign bus.read_data2 = w_rd2;

  // Operands capture the port value exactly as presented, forwarded or not.
  reg_bank_oper_latch #(.DATA_W(DATA_W)) u_latch_a (
    .clk    (clk),
    .rst    (reset),
    .i_load (bus.load_a),
    .i_d    (w_rd1),
    .o_q    (w_reg_a)
  );

  reg_bank_oper_latch #(.DATA_W(DATA_W)) u_latch_b (
    .clk    (clk),
    .rst    (reset),
    .i_load (bus.load_b),
    .i_d    (w_rd2),
    .o_q    (w_reg_b)
  );

  assign bus.reg_a = w_reg_a;
  assign bus.reg_b = w_reg_b;

endmodule : reg_bank
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_bank : directed self-checking bench for reg_bank              |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_reg_bank;
  import reg_bank_pkg::*;

  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  reg_bank_if #(.DATA_W(DATA_W)) bus ();

  reg_bank #(
    .DATA_W   (DATA_W),
    .SP_RESET (227),
    .RA_RESET (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] exp_same;

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef REG_BANK_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    reset          = 1'b1;
    bus.reg_write  = 1'b0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.read_reg1  = '0;
    bus.read_reg2  = '0;
    bus.load_a     = 1'b0;
    bus.load_b     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    bus.read_reg1 = 5'd29;
    bus.read_reg2 = 5'd31;
    #1;
    chk("rst_sp", bus.read_data1, 32'd227);
    chk("rst_ra", bus.read_data2, 32'd0);
    bus.read_reg1 = 5'd5;
    #1;
    chk("rst_r5", bus.read_data1, 32'd0);
    chk("rst_reg_a", bus.reg_a, 32'd0);
    chk("rst_reg_b", bus.reg_b, 32'd0);

    // Write then zero-cycle read and operand capture
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd8;
    bus.write_data = 32'hDEADBEEF;
    tick();
    bus.reg_write = 1'b0;
    bus.read_reg1 = 5'd8;
    bus.load_a    = 1'b1;
    #1;
    chk("rd1_r8", bus.read_data1, 32'hDEADBEEF);
    tick();
    bus.load_a = 1'b0;
    chk("reg_a_r8", bus.reg_a, 32'hDEADBEEF);

    // Register 0 ignores writes and never forwards
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd0;
    bus.write_data = 32'hFFFFFFFF;
    bus.read_reg2  = 5'd0;
    #1;
    chk("r0_same_cycle", bus.read_data2, 32'd0);
    tick();
    bus.reg_write = 1'b0;
    #1;
    chk("r0_after", bus.read_data2, 32'd0);

    // Same-cycle write/read of index 9
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd9;
    bus.write_data = 32'h11;
    tick();
    bus.write_data = 32'h22;
    bus.read_reg1  = 5'd9;
    bus.read_reg2  = 5'd9;
    bus.load_a     = 1'b1;
    #1;
    chk("r9_rd1_collide", bus.read_data1, exp_same);
    chk("r9_rd2_collide", bus.read_data2, exp_same);
    tick();
    bus.reg_write = 1'b0;
    bus.load_a    = 1'b0;
    chk("r9_reg_a", bus.reg_a, exp_same);
    #1;
    chk("r9_next", bus.read_data1, 32'h22);

    // Disabled write leaves storage and held operand intact
    bus.read_reg2 = 5'd8;
    bus.load_b    = 1'b1;
    tick();
    bus.load_b     = 1'b0;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd3;
    bus.write_data = 32'hAAAA;
    tick();
    bus.reg_write  = 1'b0;
    bus.write_data = 32'h1234;
    bus.read_reg2  = 5'd3;
    tick();
    bus.read_reg1 = 5'd3;
    #1;
    chk("r3_unchanged", bus.read_data1, 32'hAAAA);
    chk("reg_b_hold", bus.reg_b, 32'hDEADBEEF);

    // Write to RA, then reset must win over a write to SP
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd31;
    bus.write_data = 32'h5555;
    tick();
    bus.read_reg2 = 5'd31;
    bus.reg_write = 1'b0;
    #1;
    chk("r31_write", bus.read_data2, 32'h5555);
    reset          = 1'b1;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd29;
    bus.write_data = 32'd5;
    bus.load_a     = 1'b1;
    bus.load_b     = 1'b1;
    tick();
    reset         = 1'b0;
    bus.reg_write = 1'b0;
    bus.load_a    = 1'b0;
    bus.load_b    = 1'b0;
    bus.read_reg1 = 5'd29;
    bus.read_reg2 = 5'd8;
    #1;
    chk("rst_pri_sp", bus.read_data1, 32'd227);
    chk("rst_clr_r8", bus.read_data2, 32'd0);
    chk("rst_pri_reg_a", bus.reg_a, 32'd0);
    chk("rst_pri_reg_b", bus.reg_b, 32'd0);
    bus.read_reg1 = 5'd31;
    #1;
    chk("rst_clr_r31", bus.read_data1, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reg_bank
`default_nettype wire

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter SP_RESET, default 227, reset value of register 29 (SP).
REQ-003 Parameter RA_RESET, default 0, reset value of register 31.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 reg_write  input  1  write enable for the write port.
REQ-007 write_reg  input  5  write address, driven by the register-destination mux.
REQ-008 write_data  input  DATA_W  write-back value.
REQ-009 read_reg1  input  5  read address port 1 (Inst.25-21, rs).
REQ-010 read_reg2  input  5  read address port 2 (Inst.20-16, rt).
REQ-011 load_a  input  1  capture read_data1 into reg_a at the clock edge.
REQ-012 load_b  input  1  capture read_data2 into reg_b at the clock edge.
REQ-013 read_data1  output  DATA_W  combinational read of read_reg1.
REQ-014 read_data2  output  DATA_W  combinational read of read_reg2.
REQ-015 reg_a  output  DATA_W  registered operand A.
REQ-016 reg_b  output  DATA_W  registered operand B.

Function
REQ-017 32 registers of DATA_W bits, indices 0-31.
REQ-018 Register 0 reads as 0 always; writes to index 0 are discarded.
REQ-019 reg_write=1 and write_reg!=0 -> storage[write_reg] takes write_data at the edge; one-cycle write latency.
REQ-020 reg_write=0 -> no storage change, regardless of write_reg/write_data.
REQ-021 read_data1/2 reflect storage contents in the same cycle as the address (zero-cycle read).
REQ-022 Same index on both read ports -> identical values on both ports.
REQ-023 load_a=1 -> reg_a takes read_data1 at the edge; load_a=0 -> reg_a holds; likewise load_b/reg_b/read_data2.
REQ-024 Write and read of the same index in one cycle: read_data returns the OLD value (no bypass), unless REQ-031 applies.
REQ-025 Simultaneous load_a and write to the captured index: reg_a captures the value as defined by REQ-024/REQ-031, never a mix.
REQ-026 Unsigned 5-bit addresses; no address wrap or out-of-range case exists.

Reset
REQ-027 reset=1 at an edge -> all registers 0 except register 29 = SP_RESET and register 31 = RA_RESET; reg_a=0, reg_b=0.
REQ-028 reset has priority over reg_write, load_a, load_b in the same cycle; the write is lost.
REQ-029 Reset asserted mid-operation takes effect at the next edge; read ports show reset values combinationally from the following cycle.

Configuration
REQ-030 Macro REG_BANK_BYPASS_EN selects write-to-read forwarding.
REQ-031 Defined: when reg_write=1, write_reg!=0 and write_reg equals a read address, that read port returns write_data in the same cycle.
REQ-032 Undefined: no forwarding; behaviour per REQ-024.
REQ-033 Index 0 never forwards in either build.

Structure
REQ-034 Shared package holds DATA_W default, register count 32, index constants REG_ZERO=0, REG_SP=29, REG_RA=31, and SP_RESET default.
REQ-035 One sub-module, reg_bank_oper_latch, implements a DATA_W load-enabled register with synchronous reset, instantiated for reg_a and reg_b.
REQ-036 Storage array and write logic stay in reg_bank.

Verification
REQ-037 Reset pulse -> read_reg1=29 gives 227, read_reg2=31 gives 0, read_reg1=5 gives 0, reg_a=reg_b=0.
REQ-038 Write 0xDEADBEEF to 8, then read_reg1=8, load_a=1 -> read_data1 0xDEADBEEF same cycle, reg_a 0xDEADBEEF next cycle.
REQ-039 reg_write=1, write_reg=0, write_data=0xFFFFFFFF -> read_reg2=0 still gives 0.
REQ-040 Reg 9=0x11; same cycle write 0x22 to 9 and read 9 -> 0x11 without REG_BANK_BYPASS_EN, 0x22 with it; 0x22 next cycle in both.
REQ-041 reset=1 with reg_write=1, write_reg=29, write_data=5 -> register 29 reads 227 after the edge.
REQ-042 reg_write=0, write_reg=3, write_data=0x1234 -> register 3 unchanged; load_b=0 -> reg_b holds prior value.
